uart_rx_word: RTL and testbench

Parametrised UART receiver that supersedes the single-byte uart_rx. It adds configurable data width, optional parity, false-start rejection and framing/parity error reporting. It also assembles consecutive received bytes into one multi-byte word, so the RSA decryption core can load operands such as ciphertext and key segments directly from the serial link.

---
 rtl/uart_rx_word.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_rx_word.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word.sv
`timescale 1ns/1ps
// uart_rx_word: parametrised UART receiver with optional parity, false-start
// rejection, framing/parity error pulses and multi-byte word assembly.
// The first received byte of a word lands in the least significant slot.
module uart_rx_word #(
  parameter int CLKS_PER_BIT   = 87,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = 0,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                                i_Clock,
  input  logic                                i_Rst_n,
  input  logic                                i_Rx_Serial,
  input  logic                                i_Word_Clear,
  output logic [DATA_BITS-1:0]                o_Byte,
  output logic                                o_Byte_Valid,
  output logic [DATA_BITS*BYTES_PER_WORD-1:0] o_Word,
  output logic                                o_Word_Valid,
  output logic                                o_Frame_Err,
  output logic                                o_Parity_Err,
  output logic                                o_Busy
);

  localparam int WORD_W = DATA_BITS * BYTES_PER_WORD;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam int BC_W   = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [BC_W-1:0]  BC_LAST   = BC_W'(BYTES_PER_WORD - 1);
  localparam logic [BC_W-1:0]  BC_ONE    = BC_W'(1);
  // Expected XOR of data bits and parity bit for a good frame.
  localparam logic PAR_ODD = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Synchroniser flops
  logic rx_meta_reg;
  logic rx_s_reg;

  // Receiver state
  state_t               state_reg,      state_next;
  logic [CNT_W-1:0]     clk_cnt_reg,    clk_cnt_next;
  logic [IDX_W-1:0]     bit_idx_reg,    bit_idx_next;
  logic [DATA_BITS-1:0] data_sr_reg,    data_sr_next;
  logic                 par_bad_reg,    par_bad_next;

  // Output and word-assembly state
  logic [DATA_BITS-1:0] byte_reg,       byte_next;
  logic                 byte_valid_reg, byte_valid_next;
  logic                 frame_err_reg,  frame_err_next;
  logic                 parity_err_reg, parity_err_next;
  logic [BC_W-1:0]      byte_cnt_reg,   byte_cnt_next;
  logic [WORD_W-1:0]    word_reg,       word_next;
  logic                 word_valid_reg, word_valid_next;

  logic [DATA_BITS-1:0] slot_reg [BYTES_PER_WORD];
  logic [WORD_W-1:0]    word_assembled;
  logic                 frame_good;
  logic                 slot_we;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= i_Rx_Serial;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // State register for the frame FSM, counters and output registers.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg      <= ST_IDLE;
      clk_cnt_reg    <= '0;
      bit_idx_reg    <= '0;
      data_sr_reg    <= '0;
      par_bad_reg    <= 1'b0;
      byte_reg       <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      byte_cnt_reg   <= '0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      clk_cnt_reg    <= clk_cnt_next;
      bit_idx_reg    <= bit_idx_next;
      data_sr_reg    <= data_sr_next;
      par_bad_reg    <= par_bad_next;
      byte_reg       <= byte_next;
      byte_valid_reg <= byte_valid_next;
      frame_err_reg  <= frame_err_next;
      parity_err_reg <= parity_err_next;
      byte_cnt_reg   <= byte_cnt_next;
      word_reg       <= word_next;
      word_valid_reg <= word_valid_next;
    end
  end

  // Next-state logic: bit timing, sampling, error decisions and word assembly.
  always_comb begin
    state_next      = state_reg;
    clk_cnt_next    = clk_cnt_reg;
    bit_idx_next    = bit_idx_reg;
    data_sr_next    = data_sr_reg;
    par_bad_next    = par_bad_reg;
    byte_next       = byte_reg;
    byte_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;
    byte_cnt_next   = byte_cnt_reg;
    word_next       = word_reg;
    word_valid_next = 1'b0;
    frame_good      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!rx_s_reg) begin
          state_next   = ST_START;
          clk_cnt_next = '0;
        end
      end

      ST_START: begin
        if (clk_cnt_reg == HALF_LAST) begin
          clk_cnt_next = '0;
          if (rx_s_reg) begin
            // Line went back high before mid-bit: glitch, not a frame.
            state_next = ST_IDLE;
          end else begin
            state_next   = ST_DATA;
            bit_idx_next = '0;
            par_bad_next = 1'b0;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (clk_cnt_reg == BIT_LAST) begin
          clk_cnt_next = '0;
          data_sr_next = {rx_s_reg, data_sr_reg[DATA_BITS-1:1]};
          if (bit_idx_reg == IDX_LAST) begin
            state_next = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_ONE;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_ONE;
        end
      end

      ST_PARITY: begin
        if (clk_cnt_reg == BIT_LAST) begin
          clk_cnt_next = '0;
          par_bad_next = ((^data_sr_reg) ^ rx_s_reg) != PAR_ODD;
          state_next   = ST_STOP;
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_ONE;
        end
      end

      ST_STOP: begin
        if (clk_cnt_reg == BIT_LAST) begin
          // Leave at mid stop bit so a back-to-back start edge is caught.
          clk_cnt_next = '0;
          state_next   = ST_IDLE;
          if (!rx_s_reg) begin
            frame_err_next = 1'b1;
          end else if (par_bad_reg) begin
            parity_err_next = 1'b1;
          end else begin
            frame_good = 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next   = ST_IDLE;
        clk_cnt_next = '0;
      end
    endcase

    if (frame_good) begin
      byte_next       = data_sr_reg;
      byte_valid_next = 1'b1;
    end

    // Clear and any error drop the partial word; clear beats a good byte.
    if (i_Word_Clear || frame_err_next || parity_err_next) begin
      byte_cnt_next = '0;
    end else if (frame_good) begin
      if (byte_cnt_reg == BC_LAST) begin
        byte_cnt_next   = '0;
        word_next       = word_assembled;
        word_valid_next = 1'b1;
      end else begin
        byte_cnt_next = byte_cnt_reg + BC_ONE;
      end
    end
  end

  assign slot_we = frame_good && !i_Word_Clear;

  // One holding slot per byte position; the incoming byte bypasses its slot
  // so the completed word can be registered in the same cycle.
  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_slot
      // Capture a good byte into the slot selected by the byte counter.
      always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
          slot_reg[gi] <= '0;
        end else if (slot_we && (byte_cnt_reg == BC_W'(gi))) begin
          slot_reg[gi] <= data_sr_reg;
        end
      end

      assign word_assembled[gi*DATA_BITS +: DATA_BITS] =
        (byte_cnt_reg == BC_W'(gi)) ? data_sr_reg : slot_reg[gi];
    end
  endgenerate

  assign o_Byte       = byte_reg;
  assign o_Byte_Valid = byte_valid_reg;
  assign o_Word       = word_reg;
  assign o_Word_Valid = word_valid_reg;
  assign o_Frame_Err  = frame_err_reg;
  assign o_Parity_Err = parity_err_reg;
  assign o_Busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_word.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_word: a no-parity instance (dut0) and an
// even-parity instance (dut1); expected bytes/words queued per stimulus.
module tb_uart_rx_word;

  localparam int CPB = 87;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx0, rx1, clr0, clr1;

  logic [7:0]  ob0, ob1;
  logic [31:0] ow0, ow1;
  logic        bv0, wv0, fe0, pe0, busy0;
  logic        bv1, wv1, fe1, pe1, busy1;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_byte_q[$];
  logic [31:0] exp_word_q[$];
  logic [7:0]  exp_byte_p_q[$];
  int unexp0 = 0, unexp1 = 0;
  int ferr0 = 0, perr0 = 0, ferr0_exp = 0;
  int ferr1 = 0, perr1 = 0, wvcnt1 = 0;

  int          m_cnt  = 0;
  logic [31:0] m_word = '0;

  always #50 clk = ~clk;

  uart_rx_word #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .BYTES_PER_WORD(4)) dut0 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx0), .i_Word_Clear(clr0),
    .o_Byte(ob0), .o_Byte_Valid(bv0), .o_Word(ow0), .o_Word_Valid(wv0),
    .o_Frame_Err(fe0), .o_Parity_Err(pe0), .o_Busy(busy0)
  );

  uart_rx_word #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .BYTES_PER_WORD(4)) dut1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx1), .i_Word_Clear(clr1),
    .o_Byte(ob1), .o_Byte_Valid(bv1), .o_Word(ow1), .o_Word_Valid(wv1),
    .o_Frame_Err(fe1), .o_Parity_Err(pe1), .o_Busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard model of a good byte arriving at dut0.
  task automatic exp_good(input logic [7:0] b);
    exp_byte_q.push_back(b);
    m_word[m_cnt*8 +: 8] = b;
    m_cnt++;
    if (m_cnt == 4) begin
      exp_word_q.push_back(m_word);
      m_cnt = 0;
    end
  endtask

  task automatic exp_drop();
    m_cnt = 0;
  endtask

  task automatic drive_bit(input int d, input logic b);
    if (d == 0) rx0 = b; else rx1 = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input int d, input logic [7:0] data, input logic has_par,
                      input logic par, input logic stop);
    $display("tx dut%0d data=%02h par_en=%0b par=%0b stop=%0b", d, data, has_par, par, stop);
    drive_bit(d, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d, data[i]);
    if (has_par) drive_bit(d, par);
    drive_bit(d, stop);
    if (d == 0) rx0 = 1'b1; else rx1 = 1'b1;
  endtask

  task automatic pulse_clear();
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
  endtask

  // Let outstanding pulses land, then require all expectations consumed.
  task automatic drain(input string tag);
    repeat (2 * CPB) @(negedge clk);
    chk({tag, "_byteq"}, exp_byte_q.size(), 0);
    chk({tag, "_wordq"}, exp_word_q.size(), 0);
    chk({tag, "_unexp"}, unexp0, 0);
    chk({tag, "_ferr"},  ferr0, ferr0_exp);
    chk({tag, "_perr"},  perr0, 0);
  endtask

  // Output monitor: pops the scoreboard on every valid pulse.
  always @(negedge clk) begin
    if (bv0 === 1'b1) begin
      if (exp_byte_q.size() == 0) begin
        unexp0++;
        $display("rx dut0 byte=%02h (no expectation)", ob0);
      end else begin
        logic [7:0] e;
        e = exp_byte_q.pop_front();
        $display("rx dut0 byte=%02h exp=%02h", ob0, e);
        chk("byte0", ob0, e);
      end
    end
    if (wv0 === 1'b1) begin
      chk("word_with_byte", bv0, 1'b1);
      if (exp_word_q.size() == 0) begin
        unexp0++;
        $display("rx dut0 word=%08h (no expectation)", ow0);
      end else begin
        logic [31:0] w;
        w = exp_word_q.pop_front();
        $display("rx dut0 word=%08h exp=%08h", ow0, w);
        chk("word0", ow0, w);
      end
    end
    if (fe0 === 1'b1) begin ferr0++; $display("rx dut0 frame_err"); end
    if (pe0 === 1'b1) begin perr0++; $display("rx dut0 parity_err"); end
    if (bv1 === 1'b1) begin
      if (exp_byte_p_q.size() == 0) begin
        unexp1++;
        $display("rx dut1 byte=%02h (no expectation)", ob1);
      end else begin
        logic [7:0] e1;
        e1 = exp_byte_p_q.pop_front();
        $display("rx dut1 byte=%02h exp=%02h", ob1, e1);
        chk("byte1", ob1, e1);
      end
    end
    if (wv1 === 1'b1) wvcnt1++;
    if (fe1 === 1'b1) begin ferr1++; $display("rx dut1 frame_err"); end
    if (pe1 === 1'b1) begin perr1++; $display("rx dut1 parity_err"); end
  end

  initial begin
    rx0 = 1'b1; rx1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_byte",  ob0, 8'h00);
    chk("rst_word",  ow0, 32'h0);
    chk("rst_busy",  busy0, 1'b0);
    chk("rst_bv",    bv0, 1'b0);
    chk("rst_wv",    wv0, 1'b0);
    chk("rst_fe",    fe0, 1'b0);
    chk("rst_pe",    pe0, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte: no word yet
    exp_good(8'hAB);
    send(0, 8'hAB, 1'b0, 1'b0, 1'b1);
    drain("basic");

    // Four back-to-back bytes into a fresh word
    pulse_clear();
    exp_drop();
    for (int i = 1; i <= 4; i++) begin
      exp_good(8'(i));
      send(0, 8'(i), 1'b0, 1'b0, 1'b1);
    end
    drain("word");
    chk("word_hold", ow0, 32'h04030201);

    // False start: 20 cycles low, then high
    rx0 = 1'b0;
    repeat (20) @(negedge clk);
    chk("fs_busy", busy0, 1'b1);
    rx0 = 1'b1;
    repeat (60) @(negedge clk);
    chk("fs_idle", busy0, 1'b0);
    exp_good(8'h5A);
    send(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    drain("falsestart");

    // Framing error drops the partial word (5A)
    ferr0_exp++;
    exp_drop();
    send(0, 8'hC3, 1'b0, 1'b0, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    drain("ferr");
    foreach (exp_word_q[i]) ; // no-op keeps queue untouched
    exp_good(8'h11); send(0, 8'h11, 1'b0, 1'b0, 1'b1);
    exp_good(8'h22); send(0, 8'h22, 1'b0, 1'b0, 1'b1);
    exp_good(8'h33); send(0, 8'h33, 1'b0, 1'b0, 1'b1);
    exp_good(8'h44); send(0, 8'h44, 1'b0, 1'b0, 1'b1);
    drain("ferr_word");
    chk("ferr_word_hold", ow0, 32'h44332211);

    // Even parity on dut1: 8'h07 has three ones, so parity bit 1 is correct
    exp_byte_p_q.push_back(8'h07);
    send(1, 8'h07, 1'b1, 1'b1, 1'b1);
    send(1, 8'h07, 1'b1, 1'b0, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    chk("par_byteq", exp_byte_p_q.size(), 0);
    chk("par_unexp", unexp1, 0);
    chk("par_perr",  perr1, 1);
    chk("par_ferr",  ferr1, 0);
    chk("par_wv",    wvcnt1, 0);

    // Word clear between bytes
    exp_good(8'hE1); send(0, 8'hE1, 1'b0, 1'b0, 1'b1);
    exp_good(8'hE2); send(0, 8'hE2, 1'b0, 1'b0, 1'b1);
    pulse_clear();
    exp_drop();
    exp_good(8'hA0); send(0, 8'hA0, 1'b0, 1'b0, 1'b1);
    exp_good(8'hA1); send(0, 8'hA1, 1'b0, 1'b0, 1'b1);
    exp_good(8'hA2); send(0, 8'hA2, 1'b0, 1'b0, 1'b1);
    exp_good(8'hA3); send(0, 8'hA3, 1'b0, 1'b0, 1'b1);
    drain("clear");
    chk("clear_word", ow0, 32'hA3A2A1A0);

    // Reset in the middle of a frame's data bits
    exp_good(8'h77); send(0, 8'h77, 1'b0, 1'b0, 1'b1);
    repeat (CPB) @(negedge clk);
    rx0 = 1'b0;
    repeat (2 * CPB + 10) @(negedge clk);
    chk("mid_busy", busy0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy0, 1'b0);
    chk("mrst_byte", ob0, 8'h00);
    chk("mrst_word", ow0, 32'h0);
    rx0 = 1'b1;
    exp_drop();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);
    exp_good(8'h9C); send(0, 8'h9C, 1'b0, 1'b0, 1'b1);
    exp_good(8'h3E); send(0, 8'h3E, 1'b0, 1'b0, 1'b1);
    exp_good(8'hF0); send(0, 8'hF0, 1'b0, 1'b0, 1'b1);
    exp_good(8'h0F); send(0, 8'h0F, 1'b0, 1'b0, 1'b1);
    drain("rst");
    chk("rst_word_after", ow0, 32'h0FF03E9C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
